// File: rtl/regfile_write_arbiter.sv
// Two-port writeback arbiter for the RegisterFile write port: per-port FIFOs, round-robin drain,
// combinational read-after-write hazard flag. Optional macro ZERO_REG_EN makes register 0 hardwired zero.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0Valid,
  output logic                  req0Ready,
  input  logic [ADDR_WIDTH-1:0] req0Addr,
  input  logic [DATA_WIDTH-1:0] req0Data,
  input  logic                  req1Valid,
  output logic                  req1Ready,
  input  logic [ADDR_WIDTH-1:0] req1Addr,
  input  logic [DATA_WIDTH-1:0] req1Data,
  output logic [ADDR_WIDTH-1:0] writeReg,
  output logic [DATA_WIDTH-1:0] writeFile,
  output logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  output logic                  hazard
);

  localparam int NPORTS = 2;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [NPORTS-1:0]                 req_valid;
  logic [NPORTS-1:0]                 req_ready;
  logic [NPORTS-1:0]                 push;
  logic [NPORTS-1:0]                 pop;
  logic [NPORTS-1:0]                 not_empty;
  logic [NPORTS-1:0]                 fifo_hit;
  logic [NPORTS-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NPORTS-1:0][DATA_WIDTH-1:0] req_data;
  logic [NPORTS-1:0][ADDR_WIDTH-1:0] head_addr;
  logic [NPORTS-1:0][DATA_WIDTH-1:0] head_data;

  logic                  last_grant_q, last_grant_d;
  logic                  reg_write_q, reg_write_d;
  logic [ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
  logic [DATA_WIDTH-1:0] write_file_q, write_file_d;
  logic                  grant_valid;
  logic                  grant;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0] grant_data;

  assign req_valid = {req1Valid, req0Valid};
  assign req_addr  = {req1Addr, req0Addr};
  assign req_data  = {req1Data, req0Data};
  assign req0Ready = req_ready[0];
  assign req1Ready = req_ready[1];

  // A hardwired-zero register can never be the target of a pending write.
  function automatic logic addr_hits(input logic [ADDR_WIDTH-1:0] a,
                                     input logic [ADDR_WIDTH-1:0] r1,
                                     input logic [ADDR_WIDTH-1:0] r2);
`ifdef ZERO_REG_EN
    return (a != '0) && ((a == r1) || (a == r2));
`else
    return (a == r1) || (a == r2);
`endif
  endfunction

  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_fifo
      logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
      logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
      logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
      logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
      logic [PTR_W:0]        count;
      logic [PTR_W:0]        offset;
      logic                  full;
      logic                  hit;

      assign count          = wr_ptr_q - rd_ptr_q;
      assign full           = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                              (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
      assign not_empty[gi]  = (wr_ptr_q != rd_ptr_q);
      // Ready depends only on fullness: a same-cycle pop never frees a slot for the push.
      assign req_ready[gi]  = !full;
      assign push[gi]       = req_valid[gi] && !full;
      assign wr_ptr_d       = push[gi] ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      assign rd_ptr_d       = pop[gi]  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      assign head_addr[gi]  = mem_addr[rd_ptr_q[PTR_W-1:0]];
      assign head_data[gi]  = mem_data[rd_ptr_q[PTR_W-1:0]];
      assign fifo_hit[gi]   = hit;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
        end
      end

      always_ff @(posedge clock) begin
        if (push[gi]) begin
          mem_addr[wr_ptr_q[PTR_W-1:0]] <= req_addr[gi];
          mem_data[wr_ptr_q[PTR_W-1:0]] <= req_data[gi];
        end
      end

      // An entry is live when its distance from the read pointer is below the occupancy.
      always_comb begin
        hit    = 1'b0;
        offset = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          offset = {1'b0, PTR_W'(i) - rd_ptr_q[PTR_W-1:0]};
          if ((offset < count) && addr_hits(mem_addr[i], readReg1, readReg2)) begin
            hit = 1'b1;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    grant_valid = |not_empty;
    grant       = 1'b0;
    if (not_empty[0] && not_empty[1]) begin
      grant = ~last_grant_q;
    end else if (not_empty[1]) begin
      grant = 1'b1;
    end
    pop = '0;
    if (grant_valid) begin
      pop[grant] = 1'b1;
    end
  end

  assign grant_addr = head_addr[grant];
  assign grant_data = head_data[grant];

`ifdef ZERO_REG_EN
  assign commit = grant_valid && (grant_addr != '0);
`else
  assign commit = grant_valid;
`endif

  always_comb begin
    last_grant_d = grant_valid ? grant : last_grant_q;
    reg_write_d  = commit;
    write_reg_d  = commit ? grant_addr : write_reg_q;
    write_file_d = commit ? grant_data : write_file_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_file_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_file_q <= write_file_d;
    end
  end

  assign regWrite  = reg_write_q;
  assign writeReg  = write_reg_q;
  assign writeFile = write_file_q;
  assign hazard    = (|fifo_hit) || (reg_write_q && addr_hits(write_reg_q, readReg1, readReg2));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: per-port expected-write queues filled at enqueue,
// drained by a monitor on every regWrite pulse. Port of origin is encoded in data bit 9.
module tb_regfile_write_arbiter;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0Valid = 1'b0, req1Valid = 1'b0;
  logic          req0Ready, req1Ready;
  logic [AW-1:0] req0Addr = '0, req1Addr = '0;
  logic [DW-1:0] req0Data = '0, req1Data = '0;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] writeFile;
  logic          regWrite;
  logic [AW-1:0] readReg1 = 3'd7, readReg2 = 3'd6;
  logic          hazard;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0Valid(req0Valid), .req0Ready(req0Ready), .req0Addr(req0Addr), .req0Data(req0Data),
    .req1Valid(req1Valid), .req1Ready(req1Ready), .req1Addr(req1Addr), .req1Data(req1Data),
    .writeReg(writeReg), .writeFile(writeFile), .regWrite(regWrite),
    .readReg1(readReg1), .readReg2(readReg2), .hazard(hazard)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q0[$];
  wr_t           exp_q1[$];
  int            grant_log[$];
  int            vectors_applied = 0;
  int            miscompares = 0;
  int            write_count = 0;
  logic [DW-1:0] rf_model [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic bit is_zero_reg(input logic [AW-1:0] a);
`ifdef ZERO_REG_EN
    return (a == '0);
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clock) begin
    if (reset_n && regWrite) begin : mon
      wr_t e;
      int  port;
      port = writeFile[9] ? 1 : 0;
      write_count++;
      grant_log.push_back(port);
      rf_model[writeReg] = writeFile;
      if (port == 0) begin
        check_eq("p0_sb_has_entry", exp_q0.size() > 0, 1);
        if (exp_q0.size() > 0) begin
          e = exp_q0.pop_front();
          check_eq("p0_addr", writeReg, e.addr);
          check_eq("p0_data", writeFile, e.data);
        end
      end else begin
        check_eq("p1_sb_has_entry", exp_q1.size() > 0, 1);
        if (exp_q1.size() > 0) begin
          e = exp_q1.pop_front();
          check_eq("p1_addr", writeReg, e.addr);
          check_eq("p1_data", writeFile, e.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    grant_log.delete();
  endtask

  // One cycle of stimulus; expectation recorded only if the port accepts it at this edge.
  task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0Valid = v0; req0Addr = a0; req0Data = d0;
    req1Valid = v1; req1Addr = a1; req1Data = d1;
    if (v0 && req0Ready && !is_zero_reg(a0)) exp_q0.push_back(wr_t'({a0, d0}));
    if (v1 && req1Ready && !is_zero_reg(a1)) exp_q1.push_back(wr_t'({a1, d1}));
    @(posedge clock);
    #1;
    req0Valid = 1'b0;
    req1Valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q0.size() > 0 || exp_q1.size() > 0) && n < 40) begin
      tick(1);
      n++;
    end
    tick(2);
    check_eq("drain_q0_empty", exp_q0.size(), 0);
    check_eq("drain_q1_empty", exp_q1.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    // Reset state
    do_reset();
    check_eq("rst_regWrite", regWrite, 0);
    check_eq("rst_writeReg", writeReg, 0);
    check_eq("rst_writeFile", writeFile, 0);
    check_eq("rst_req0Ready", req0Ready, 1);
    check_eq("rst_req1Ready", req1Ready, 1);
    check_eq("rst_hazard", hazard, 0);

    // Single push, one-cycle latency to regWrite
    drive(1, 3'd4, 16'd17, 0, 3'd0, 16'd0);
    check_eq("t1_no_write_at_push_edge", regWrite, 0);
    tick(1);
    check_eq("t1_regWrite", regWrite, 1);
    check_eq("t1_writeReg", writeReg, 4);
    check_eq("t1_writeFile", writeFile, 17);
    tick(1);
    check_eq("t1_pulse_ends", regWrite, 0);
    check_eq("t1_hold_writeFile", writeFile, 17);
    check_eq("t1_rf4", rf_model[4], 17);
    drain();

    // Both ports saturating: alternating grants, port 0 first
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, AW'((i % 7) + 1), DW'(32'h100 + i), 1, AW'((i % 5) + 2), DW'(32'h200 + i));
    end
    drain();
    check_eq("t2_enough_grants", grant_log.size() >= 6, 1);
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("t2_grant%0d", k), grant_log[k], k % 2);
    end

    // req1Ready falls only with two entries; valid while not ready is dropped
    do_reset();
    drive(1, 3'd1, 16'h031, 1, 3'd2, 16'h2A0);
    check_eq("t3_ready1_one_entry", req1Ready, 1);
    drive(1, 3'd1, 16'h032, 1, 3'd2, 16'h2A1);
    check_eq("t3_ready1_full", req1Ready, 0);
    drive(1, 3'd1, 16'h033, 1, 3'd2, 16'h2A2);
    check_eq("t3_ready1_after_pop", req1Ready, 1);
    check_eq("t3_ready0_full", req0Ready, 0);
    drain();

    // Hazard window for a queued / in-flight write
    do_reset();
    readReg1 = 3'd5; readReg2 = 3'd6;
    req1Valid = 1'b1; req1Addr = 3'd5; req1Data = 16'h205;
    if (req1Ready) exp_q1.push_back(wr_t'({3'd5, 16'h205}));
    #1;
    check_eq("t4_hazard_push_cycle", hazard, 0);
    @(posedge clock);
    #1;
    req1Valid = 1'b0;
    check_eq("t4_hazard_queued", hazard, 1);
    readReg1 = 3'd1;
    #1;
    check_eq("t4_hazard_r2_nomatch", hazard, 0);
    readReg2 = 3'd5;
    #1;
    check_eq("t4_hazard_r2_match", hazard, 1);
    readReg1 = 3'd5; readReg2 = 3'd6;
    tick(1);
    check_eq("t4_inflight_regWrite", regWrite, 1);
    check_eq("t4_hazard_inflight", hazard, 1);
    tick(1);
    check_eq("t4_hazard_cleared", hazard, 0);
    drain();
    readReg1 = 3'd7;

    // Reset mid-drain discards everything
    do_reset();
    readReg1 = 3'd3;
    drive(1, 3'd2, 16'h150, 1, 3'd3, 16'h250);
    drive(1, 3'd2, 16'h151, 1, 3'd3, 16'h251);
    check_eq("t5_inflight", regWrite, 1);
    check_eq("t5_hazard_before", hazard, 1);
    reset_n = 1'b0;
    #1;
    check_eq("t5_regWrite_cleared", regWrite, 0);
    check_eq("t5_ready0", req0Ready, 1);
    check_eq("t5_ready1", req1Ready, 1);
    check_eq("t5_hazard_cleared", hazard, 0);
    exp_q0.delete();
    exp_q1.delete();
    wc = write_count;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick(6);
    check_eq("t5_no_writes_after_reset", write_count, wc);
    readReg1 = 3'd7;

    // Writes to register 0
    do_reset();
    readReg1 = 3'd0; readReg2 = 3'd7;
    drive(1, 3'd3, 16'h033, 1, 3'd0, 16'hFFFF);
`ifdef ZERO_REG_EN
    check_eq("t6_hazard_r0", hazard, 0);
`else
    check_eq("t6_hazard_r0", hazard, 1);
`endif
    drive(1, 3'd2, 16'h022, 0, 3'd0, 16'd0);
    check_eq("t6_first_write", writeFile, 16'h033);
    tick(1);
`ifdef ZERO_REG_EN
    check_eq("t6_r0_regWrite", regWrite, 0);
    check_eq("t6_r0_hazard", hazard, 0);
`else
    check_eq("t6_r0_regWrite", regWrite, 1);
    check_eq("t6_r0_writeReg", writeReg, 0);
    check_eq("t6_r0_writeFile", writeFile, 16'hFFFF);
`endif
    tick(1);
    check_eq("t6_next_regWrite", regWrite, 1);
    check_eq("t6_next_writeFile", writeFile, 16'h022);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
